// File: rtl/iob_iob2axi_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// iob_iob2axi_wr_ctrl_if
// Burst control bus between the write-transfer splitter and the AXI write
// burst engine.
//   run_o          splitter -> engine  one-cycle burst strobe
//   addr_o         splitter -> engine  burst start byte address
//   length_o       splitter -> engine  burst beats minus 1
//   engine_ready_i engine -> splitter  engine idle
//   engine_error_i engine -> splitter  status of the last burst
// master = splitter side, slave = engine side.
// ---------------------------------------------------------------------------
interface iob_iob2axi_wr_ctrl_if #(
    parameter int ADDR_W    = 32,
    parameter int AXI_LEN_W = 8
);
    logic                 run_o;
    logic [ADDR_W-1:0]    addr_o;
    logic [AXI_LEN_W-1:0] length_o;
    logic                 engine_ready_i;
    logic                 engine_error_i;

    modport master (
        output run_o, addr_o, length_o,
        input  engine_ready_i, engine_error_i
    );

    modport slave (
        input  run_o, addr_o, length_o,
        output engine_ready_i, engine_error_i
    );
endinterface

// File: rtl/iob_iob2axi_wr_ctrl.sv
// ---------------------------------------------------------------------------
// iob_iob2axi_wr_ctrl
// Splits one write command (base byte address + word count) into AXI INCR
// bursts of at most 2^AXI_LEN_W beats that never cross a 4 KiB boundary,
// and issues them one at a time to the burst engine.
// Ports:
//   clk_i, arst_n_i  clock, asynchronous active-low reset
//   start_i          command strobe (sampled only while idle)
//   base_addr_i      command start byte address (low bits aligned to word)
//   nwords_i         words to write, 0 = no-op
//   busy_o           command in progress
//   done_o           one-cycle completion pulse
//   error_o          command status, valid from done_o until next start
//   eng              burst control bus to the engine (master side)
// ADDR_W must be >= 13; DATA_W is a power of two between 8 and 1024.
// ---------------------------------------------------------------------------
module iob_iob2axi_wr_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int WORDS_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [WORDS_W-1:0]   nwords_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    iob_iob2axi_wr_ctrl_if.master eng
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);

    // Common width wide enough for the word count, 2^AXI_LEN_W and 4096.
    localparam int CW_A = (WORDS_W > AXI_LEN_W + 1) ? WORDS_W : AXI_LEN_W + 1;
    localparam int CW   = (CW_A > 13) ? CW_A : 13;

    localparam logic [CW-1:0]     MAX_BEATS  = CW'(1) << AXI_LEN_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << BYTE_SH) - ADDR_W'(1));

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    cur_addr;
    logic [WORDS_W-1:0]   remaining;
    logic [AXI_LEN_W:0]   beats_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [AXI_LEN_W-1:0] len_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    // ---- burst size: min(remaining, 2^AXI_LEN_W, words to 4 KiB) ----
    logic [12:0]        to4k_b;
    logic [CW-1:0]      rem_w;
    logic [CW-1:0]      to4k_w;
    logic [CW-1:0]      min1_w;
    logic [AXI_LEN_W:0] beats_calc;

    assign to4k_b = 13'h1000 - {1'b0, cur_addr[11:0]};
    // cur_addr is word aligned, so this shift is an exact division.
    assign to4k_w = CW'(to4k_b >> BYTE_SH);
    assign rem_w  = CW'(remaining);
    assign min1_w = (rem_w < MAX_BEATS) ? rem_w : MAX_BEATS;
    // Whichever operand wins is <= 2^AXI_LEN_W, so it fits in AXI_LEN_W+1 bits.
    assign beats_calc = (min1_w < to4k_w) ? min1_w[AXI_LEN_W:0]
                                          : to4k_w[AXI_LEN_W:0];

    // ---- progress after a completed burst ----
    logic [ADDR_W-1:0]  addr_step;
    logic [WORDS_W-1:0] rem_next;

    assign addr_step = ADDR_W'(beats_q) << BYTE_SH;
    // beats never exceeds remaining, so the narrowing cast is lossless.
    assign rem_next  = remaining - WORDS_W'(beats_q);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (nwords_i != '0) begin
                            cur_addr  <= base_addr_i & ALIGN_MASK;
                            remaining <= nwords_i;
                            busy_q    <= 1'b1;
                            state     <= CALC;
                        end else begin
                            // Empty command completes without touching the engine.
                            done_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    addr_q  <= cur_addr;
                    beats_q <= beats_calc;
                    // beats=2^AXI_LEN_W has zero low bits; the wrap gives all ones.
                    len_q   <= beats_calc[AXI_LEN_W-1:0] - AXI_LEN_W'(1);
                    state   <= ISSUE;
                end
                ISSUE: begin
                    if (eng.engine_ready_i) state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!eng.engine_ready_i) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (eng.engine_ready_i) begin
                        cur_addr  <= cur_addr + addr_step;
                        remaining <= rem_next;
                        // First error ends the command; no further bursts.
                        if (eng.engine_error_i || rem_next == '0) begin
                            err_q  <= eng.engine_error_i;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // run_o is qualified by the live ready so the strobe only ever lands in a
    // cycle where the engine can take it; the state itself is registered.
    assign eng.run_o    = (state == ISSUE) && eng.engine_ready_i;
    assign eng.addr_o   = addr_q;
    assign eng.length_o = len_q;

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = err_q;

endmodule

// File: tb/tb_iob_iob2axi_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_iob2axi_wr_ctrl
// Directed bench: stimulus pushes expected bursts and completion status into
// queues; a monitor pops and compares whenever run_o or done_o is seen.
// A small engine model answers each run_o with a ready low/high handshake.
// ---------------------------------------------------------------------------
module tb_iob_iob2axi_wr_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int AXI_LEN_W = 8;
    localparam int WORDS_W   = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [AXI_LEN_W-1:0] len;
    } burst_t;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic [WORDS_W-1:0] nwords;
    logic               busy;
    logic               done;
    logic               error;

    burst_t exp_bursts[$];
    logic   exp_err[$];
    burst_t m_exp;
    logic   m_err;

    int checks = 0;
    int errors = 0;
    int eng_bursts = 0;
    int err_at = -1;

    always #5 clk = ~clk;

    iob_iob2axi_wr_ctrl_if #(.ADDR_W(ADDR_W), .AXI_LEN_W(AXI_LEN_W)) eng_if ();

    iob_iob2axi_wr_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AXI_LEN_W(AXI_LEN_W),
        .WORDS_W  (WORDS_W)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .start_i    (start),
        .base_addr_i(base_addr),
        .nwords_i   (nwords),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .eng        (eng_if)
    );

    // Engine model: after a run_o it drops ready for three cycles, then
    // raises it with the planned error status for that burst.
    initial begin
        eng_if.engine_ready_i = 1'b1;
        eng_if.engine_error_i = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_if.run_o) begin
                eng_bursts++;
                eng_if.engine_error_i = 1'b0;
                @(negedge clk);
                eng_if.engine_ready_i = 1'b0;
                repeat (3) @(negedge clk);
                eng_if.engine_error_i = (eng_bursts == err_at);
                eng_if.engine_ready_i = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (eng_if.run_o) begin
            checks++;
            if (exp_bursts.size() == 0) begin
                errors++;
                $display("FAIL burst: unexpected run_o addr=%h len=%0d", eng_if.addr_o, eng_if.length_o);
            end else begin
                m_exp = exp_bursts.pop_front();
                if (eng_if.addr_o !== m_exp.addr || eng_if.length_o !== m_exp.len) begin
                    errors++;
                    $display("FAIL burst: got addr=%h len=%0d want addr=%h len=%0d",
                             eng_if.addr_o, eng_if.length_o, m_exp.addr, m_exp.len);
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_err.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected done_o");
            end else begin
                m_err = exp_err.pop_front();
                if (error !== m_err || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done: got error=%b busy=%b want error=%b busy=0", error, busy, m_err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [AXI_LEN_W-1:0] l);
        burst_t b;
        b.addr = a;
        b.len  = l;
        exp_bursts.push_back(b);
    endtask

    // Drive start for one cycle; returns at the negedge after it was sampled.
    task automatic send(input logic [ADDR_W-1:0] a, input logic [WORDS_W-1:0] n);
        start     = 1'b1;
        base_addr = a;
        nwords    = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done_o is high, so a following send()
    // lands its start in the done cycle.
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done_o timeout got 0 want 1", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n    = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        nwords    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        check("rst_error",  32'(error), 0);
        check("rst_run",    32'(eng_if.run_o), 0);
        check("rst_addr",   eng_if.addr_o, 0);
        check("rst_length", 32'(eng_if.length_o), 0);
        arst_n = 1'b1;
        @(negedge clk);

        // Single short burst, with start-to-run latency.
        push(32'h1000, 8'd9);
        exp_err.push_back(1'b0);
        send(32'h1000, 16'd10);
        check("lat_calc_busy", 32'(busy), 1);
        check("lat_calc_run", 32'(eng_if.run_o), 0);
        @(negedge clk);
        check("lat_issue_run", 32'(eng_if.run_o), 1);
        wait_done("t1");

        // 600 words: length-limited bursts (back-to-back start).
        push(32'h000, 8'd255);
        push(32'h400, 8'd255);
        push(32'h800, 8'd87);
        exp_err.push_back(1'b0);
        send(32'h0, 16'd600);
        wait_done("t2");

        // 4 KiB boundary split.
        push(32'h0FF0, 8'd3);
        push(32'h1000, 8'd3);
        exp_err.push_back(1'b0);
        send(32'h0FF0, 16'd8);
        wait_done("t3");

        // Unaligned base: low two bits dropped.
        push(32'h1000, 8'd1);
        exp_err.push_back(1'b0);
        send(32'h1003, 16'd2);
        wait_done("t3b");

        // Exactly one maximum-length burst.
        push(32'h2000, 8'd255);
        exp_err.push_back(1'b0);
        send(32'h2000, 16'd256);
        wait_done("t3c");

        // Error on the 2nd burst stops the command.
        err_at = eng_bursts + 2;
        push(32'h000, 8'd255);
        push(32'h400, 8'd255);
        exp_err.push_back(1'b1);
        send(32'h0, 16'd600);
        wait_done("t4");
        err_at = -1;
        repeat (3) @(negedge clk);
        check("err_hold", 32'(error), 1);
        check("err_hold_busy", 32'(busy), 0);

        // Zero-length command.
        exp_err.push_back(1'b0);
        send(32'h3000, 16'd0);
        check("nw0_done", 32'(done), 1);
        check("nw0_busy", 32'(busy), 0);
        check("nw0_run",  32'(eng_if.run_o), 0);
        wait_done("t5");
        @(negedge clk);
        check("nw0_pulse", 32'(done), 0);
        check("nw0_err",   32'(error), 0);

        // Reset during WAIT_DONE of the first burst.
        push(32'h000, 8'd255);
        send(32'h0, 16'd600);
        for (int i = 0; i < 50 && eng_if.engine_ready_i; i++) @(negedge clk);
        check("mid_ack", 32'(eng_if.engine_ready_i), 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("mid_rst_busy",   32'(busy), 0);
        check("mid_rst_done",   32'(done), 0);
        check("mid_rst_error",  32'(error), 0);
        check("mid_rst_run",    32'(eng_if.run_o), 0);
        check("mid_rst_addr",   eng_if.addr_o, 0);
        check("mid_rst_length", 32'(eng_if.length_o), 0);
        repeat (6) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        push(32'h2000, 8'd3);
        exp_err.push_back(1'b0);
        send(32'h2000, 16'd4);
        wait_done("t6");

        repeat (5) @(negedge clk);
        check("bursts_left", 32'(exp_bursts.size()), 0);
        check("dones_left",  32'(exp_err.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_iob2axi_wr_ctrl.md
# iob_iob2axi_wr_ctrl

Transfer splitter that sits directly upstream of the AXI write-burst engine. It accepts one write command of arbitrary length, expressed as a base byte address and a word count. It breaks the command into legal AXI INCR bursts: each burst is at most 2^AXI_LEN_W beats and never crosses a 4 KiB boundary. The bursts are issued to the engine's run/addr/length/ready/error control port one at a time. Completion and accumulated error status are reported to the command source.

## Interface
Parameters:
- ADDR_W, 32, byte address width; must be ≥ 13.
- DATA_W, 32, data word width; power of two, 8 to 1024.
- AXI_LEN_W, 8, AXI burst length field width.
- WORDS_W, 16, width of the command word count.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  reset; one clock, asynchronous, active-low.
- start_i  in  1  command strobe; sampled only when busy_o=0.
- base_addr_i  in  ADDR_W  command start byte address; low log2(DATA_W/8) bits are forced to 0.
- nwords_i  in  WORDS_W  number of words to write; 0 is a legal no-op.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  command status; valid from the done_o cycle and held until the next accepted start.
- run_o  out  1  burst strobe to the engine.
- addr_o  out  ADDR_W  burst start byte address, held stable while the burst is outstanding.
- length_o  out  AXI_LEN_W  burst beats minus 1, held stable while the burst is outstanding.
- engine_ready_i  in  1  engine idle.
- engine_error_i  in  1  engine status of the last burst; valid once engine_ready_i has returned to 1.

## Operation
- State machine states: IDLE, CALC, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE, start_i=1, nwords_i≠0:
  - latch the aligned address into cur_addr and the count into remaining;
  - clear error_o and set busy_o;
  - go to CALC.
- IDLE, start_i=1, nwords_i=0:
  - pulse done_o the next cycle with error_o=0;
  - busy_o is never asserted and run_o never rises.
- CALC: in a single cycle compute beats = min(remaining, 2^AXI_LEN_W, to_4k), where to_4k = (4096 − cur_addr[11:0]) / (DATA_W/8). Register addr_o=cur_addr and length_o=beats−1, then go to ISSUE.
- ISSUE:
  - hold run_o=1 for exactly one cycle, and only in a cycle where engine_ready_i=1; otherwise wait in ISSUE with run_o=0;
  - after the run_o cycle, go to WAIT_ACK.
- WAIT_ACK: wait for engine_ready_i=0, then go to WAIT_DONE.
- WAIT_DONE: on engine_ready_i=1:
  - sample engine_error_i;
  - cur_addr += beats·DATA_W/8;
  - remaining −= beats.
  - If engine_error_i=1 or remaining=0: set error_o=engine_error_i, pulse done_o, clear busy_o, go to IDLE.
  - Otherwise go to CALC.
- First-error stop: after a burst error, no further bursts are issued.
- start_i is ignored while busy_o=1.
- Width rules:
  - address arithmetic wraps modulo 2^ADDR_W;
  - beats is held in AXI_LEN_W+1 bits;
  - to_4k is at most 4096/(DATA_W/8).

## Timing
- Reset values: busy_o=0, done_o=0, error_o=0, run_o=0, addr_o=0, length_o=0; state=IDLE.
- Asserting arst_n_i mid-command aborts immediately with all outputs at their reset values. The engine is reset by the same net.
- Latency from an accepted start_i to the first run_o is 2 cycles (IDLE→CALC→ISSUE) when engine_ready_i=1.
- Between bursts, from engine_ready_i returning to 1 to the next run_o, there are 2 cycles (WAIT_DONE→CALC→ISSUE).
- done_o rises in the cycle after the final WAIT_DONE exit, and busy_o falls in that same cycle.
- A back-to-back start_i in the cycle done_o=1 is accepted.

## Test plan
- DATA_W=32, base 0x1000, nwords 10 → one run_o with addr_o=0x1000, length_o=9; done_o pulses with error_o=0.
- Base 0x0, nwords 600 → three bursts: 0x000/255, 0x400/255, 0x800/87; exactly three run_o pulses.
- Base 0x0FF0, nwords 8 → two bursts: 0x0FF0/3, then 0x1000/3. No burst crosses 4 KiB.
- Base 0x0, nwords 600 with engine_error_i=1 after the 2nd burst → only 2 run_o pulses; done_o pulses with error_o=1.
- nwords 0 → done_o one cycle after start_i, error_o=0, run_o stays 0, busy_o stays 0.
- Pull arst_n_i low during WAIT_DONE of burst 1 → all outputs 0 at once. After release, a new start of 4 words at 0x2000 gives run_o with addr_o=0x2000, length_o=3.
